// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the I/D main-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } arbState_t;

  localparam int BLOCK_WORDS = 8;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  function automatic logic [15:0] blockBase(input logic [15:0] addr);
    return addr & 16'hFFF0;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - combinational grant pick; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
import mem_arb_pkg::*;

module arb_pick (
  input  logic iReq,
  input  logic dReq,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic lastGrant,
`endif
  output logic grantValid,
  output logic grantOwner
);

  always_comb begin
    grantValid = iReq | dReq;
    grantOwner = OWNER_I;
    if (iReq && dReq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grantOwner = ~lastGrant;
`else
      grantOwner = OWNER_D;
`endif
    end else if (dReq) begin
      grantOwner = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one main memory between I-cache fills and D-cache fills/writes
// Optional feature: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break instead of fixed D priority)
import mem_arb_pkg::*;

module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_busy,
  output logic        d_busy,
  output logic        i_done,
  output logic        d_done,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        fill_we_i,
  output logic        fill_we_d,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  arbState_t   state;
  logic        owner;
  logic [2:0]  issueCnt;
  logic [2:0]  retCnt;
  logic        memEnR;
  logic        memWrR;
  logic [15:0] memAddrR;
  logic [15:0] memWdataR;
  logic        grantValid;
  logic        grantOwner;
  logic        fillActive;
  logic        fillDone;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        lastGrant;
`endif

  arb_pick u_pick (
    .iReq       (i_req),
    .dReq       (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .lastGrant  (lastGrant),
`endif
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  // Returns only count while a fill owns the memory; strays in IDLE/WRITE are dropped.
  assign fillActive = (state == ISSUE) || (state == DRAIN);
  assign fillDone   = (state == DRAIN) && mem_rvalid && (retCnt == 3'(BLOCK_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWNER_I;
      issueCnt  <= 3'd0;
      retCnt    <= 3'd0;
      memEnR    <= 1'b0;
      memWrR    <= 1'b0;
      memAddrR  <= 16'd0;
      memWdataR <= 16'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastGrant <= OWNER_I;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grantValid) begin
            owner    <= grantOwner;
            issueCnt <= 3'd0;
            retCnt   <= 3'd0;
            memEnR   <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastGrant <= grantOwner;
`endif
            if (grantOwner == OWNER_D && d_wr) begin
              state     <= WRITE;
              memWrR    <= 1'b1;
              memAddrR  <= d_addr;
              memWdataR <= d_wdata;
            end else begin
              state     <= ISSUE;
              memWrR    <= 1'b0;
              memAddrR  <= blockBase((grantOwner == OWNER_D) ? d_addr : i_addr);
              memWdataR <= 16'd0;
            end
          end
        end
        ISSUE: begin
          if (mem_rvalid) retCnt <= retCnt + 3'd1;
          if (issueCnt == 3'(BLOCK_WORDS - 1)) begin
            state    <= DRAIN;
            memEnR   <= 1'b0;
            memAddrR <= 16'd0;
          end else begin
            issueCnt <= issueCnt + 3'd1;
            memAddrR <= memAddrR + 16'd2;
          end
        end
        DRAIN: begin
          if (mem_rvalid) begin
            retCnt <= retCnt + 3'd1;
            if (fillDone) state <= IDLE;
          end
        end
        WRITE: begin
          state     <= IDLE;
          memEnR    <= 1'b0;
          memWrR    <= 1'b0;
          memAddrR  <= 16'd0;
          memWdataR <= 16'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_en    = memEnR;
  assign mem_wr    = memWrR;
  assign mem_addr  = memAddrR;
  assign mem_wdata = memWdataR;

  assign fill_data = mem_rdata;
  assign fill_word = retCnt;
  assign fill_we_i = fillActive && mem_rvalid && (owner == OWNER_I);
  assign fill_we_d = fillActive && mem_rvalid && (owner == OWNER_D);

  assign i_done = fillDone && (owner == OWNER_I);
  assign d_done = (fillDone && (owner == OWNER_D)) || (state == WRITE);

  assign i_busy = i_req & ~i_done;
  assign d_busy = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        i_busy, d_busy, i_done, d_done;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i, fill_we_d;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_busy(i_busy), .d_busy(d_busy), .i_done(i_done), .d_done(d_done),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct { int due; logic [15:0] addr; } ret_t;
  ret_t retQ[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 4;

  bit nRst, raiseI, raiseD, dropAll, randMode, strayOn, checkOn;
  logic [15:0] nIAddr, nDAddr, nDWdata;
  logic nDWr;
  int iAgain, dAgain;
  bit iDoneSeen, dDoneSeen;

  int firstEn, lastEn, firstWe, iDoneCyc, dDoneCyc, iEnCyc, lateWe, lateRv, lateFrom;
  logic [15:0] iBaseWatch;
  bit doneLog[$];

  // Transaction model: one active grant, expected outputs derived from cycle offset since grant
  bit mActive, mWr, mOwner, mLast;
  logic [15:0] mAddr, mData;
  int mGrant, mLat;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelCheck();
    logic eEn, eWr, eWeI, eWeD, eIDone, eDDone;
    logic [15:0] eAddr, eWd, eData;
    int eWord, n;
    eEn = 0; eWr = 0; eWeI = 0; eWeD = 0; eIDone = 0; eDDone = 0;
    eAddr = 0; eWd = 0; eData = 0; eWord = 0; n = 0;
    if (mActive) begin
      n = cyc - mGrant;
      if (mWr) begin
        if (n == 1) begin eEn = 1; eWr = 1; eAddr = mAddr; eWd = mData; eDDone = 1; end
      end else begin
        if (n >= 1 && n <= 8) begin eEn = 1; eAddr = mAddr + 16'(2 * (n - 1)); end
        if (n >= mLat + 1 && n <= mLat + 8) begin
          eWord = n - 1 - mLat;
          eData = memWord(mAddr + 16'(2 * eWord));
          if (mOwner) eWeD = 1; else eWeI = 1;
        end
        if (n == 8 + mLat) begin if (mOwner) eDDone = 1; else eIDone = 1; end
      end
    end
    checkEq("mem_en", 32'(mem_en), 32'(eEn));
    checkEq("mem_wr", 32'(mem_wr), 32'(eWr));
    checkEq("mem_addr", 32'(mem_addr), 32'(eAddr));
    checkEq("mem_wdata", 32'(mem_wdata), 32'(eWd));
    checkEq("fill_we_i", 32'(fill_we_i), 32'(eWeI));
    checkEq("fill_we_d", 32'(fill_we_d), 32'(eWeD));
    checkEq("i_done", 32'(i_done), 32'(eIDone));
    checkEq("d_done", 32'(d_done), 32'(eDDone));
    checkEq("i_busy", 32'(i_busy), 32'(i_req & ~eIDone));
    checkEq("d_busy", 32'(d_busy), 32'(d_req & ~eDDone));
    if (eWeI || eWeD) begin
      checkEq("fill_word", 32'(fill_word), 32'(eWord));
      checkEq("fill_data", 32'(fill_data), 32'(eData));
    end else if (!mActive) begin
      checkEq("fill_word_idle", 32'(fill_word), 32'd0);
    end
  endtask

  task automatic modelEdge();
    if (!rst_n) begin
      mActive = 0;
      mLast   = 0;
    end else if (mActive) begin
      if ((mWr && cyc - mGrant == 1) || (!mWr && cyc - mGrant == 8 + mLat)) mActive = 0;
    end else if (i_req || d_req) begin
      mOwner  = (i_req && d_req) ? (RR ? !mLast : 1'b1) : d_req;
      mLast   = mOwner;
      mActive = 1;
      mGrant  = cyc;
      mLat    = lat;
      if (mOwner) begin
        mWr = d_wr; mAddr = d_wr ? d_addr : (d_addr & 16'hFFF0); mData = d_wdata;
      end else begin
        mWr = 0; mAddr = i_addr & 16'hFFF0; mData = 0;
      end
    end
  endtask

  task automatic clearObs();
    firstEn = -1; lastEn = -1; firstWe = -1; iDoneCyc = -1; dDoneCyc = -1; iEnCyc = -1;
    lateWe = 0; lateRv = 0; lateFrom = 32'h3FFF_FFFF;
    doneLog.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = nRst;
    if (iDoneSeen) begin
      iDoneSeen = 0;
      if (iAgain > 0) iAgain--;
      else if (randMode && $urandom_range(0, 3) == 0) i_addr = 16'($urandom);
      else i_req = 0;
    end
    if (dDoneSeen) begin
      dDoneSeen = 0;
      if (dAgain > 0) dAgain--;
      else if (randMode && $urandom_range(0, 3) == 0) begin
        d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end else d_req = 0;
    end
    if (raiseI) begin i_req = 1; i_addr = nIAddr; raiseI = 0; end
    if (raiseD) begin d_req = 1; d_wr = nDWr; d_addr = nDAddr; d_wdata = nDWdata; raiseD = 0; end
    if (randMode) begin
      if (!i_req && $urandom_range(0, 3) == 0) begin i_req = 1; i_addr = 16'($urandom); end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (!mActive && retQ.size() == 0) lat = $urandom_range(1, 7);
    end
    if (dropAll) begin i_req = 0; d_req = 0; dropAll = 0; end
    mem_rvalid = 0;
    mem_rdata  = 0;
    if (retQ.size() > 0 && retQ[0].due == cyc) begin
      mem_rvalid = 1;
      mem_rdata  = memWord(retQ[0].addr);
      void'(retQ.pop_front());
    end else if (strayOn && retQ.size() == 0 && (!mActive || mWr) && $urandom_range(0, 2) == 0) begin
      mem_rvalid = 1;
      mem_rdata  = 16'($urandom);
    end
    @(negedge clk);
    if (checkOn) modelCheck();
    if (mem_en === 1'b1) begin
      if (firstEn < 0) firstEn = cyc;
      lastEn = cyc;
      if (!mem_wr && mem_addr == iBaseWatch && iEnCyc < 0) iEnCyc = cyc;
      if (!mem_wr) retQ.push_back('{cyc + lat, mem_addr});
    end
    if (fill_we_i === 1'b1 || fill_we_d === 1'b1) begin
      if (firstWe < 0) firstWe = cyc;
      if (cyc >= lateFrom) lateWe++;
    end
    if (mem_rvalid && cyc >= lateFrom) lateRv++;
    if (i_done === 1'b1) begin iDoneCyc = cyc; iDoneSeen = 1; doneLog.push_back(1'b0); end
    if (d_done === 1'b1) begin dDoneCyc = cyc; dDoneSeen = 1; doneLog.push_back(1'b1); end
    modelEdge();
  endtask

  initial begin
    rst_n = 0; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_rvalid = 0; mem_rdata = 0;
    nRst = 0; raiseI = 0; raiseD = 0; dropAll = 0; randMode = 0; strayOn = 0; checkOn = 0;
    nIAddr = 0; nDAddr = 0; nDWdata = 0; nDWr = 0; iAgain = 0; dAgain = 0;
    iDoneSeen = 0; dDoneSeen = 0; iBaseWatch = 16'hFFFF;
    mActive = 0; mWr = 0; mOwner = 0; mLast = 0; mAddr = 0; mData = 0; mGrant = 0; mLat = 4;
    clearObs();

    step();
    checkOn = 1;
    step();
    checkEq("rst_mem_en", 32'(mem_en), 32'd0);
    checkEq("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkEq("rst_fill_we", 32'({fill_we_i, fill_we_d}), 32'd0);
    checkEq("rst_done", 32'({i_done, d_done}), 32'd0);
    checkEq("rst_fill_word", 32'(fill_word), 32'd0);
    nRst = 1;
    step();

    // Fill timing, latency 4
    lat = 4; clearObs(); cyc = -1;
    raiseI = 1; nIAddr = 16'h1236;
    repeat (16) step();
    checkEq("fill_first_en", 32'(firstEn), 32'd1);
    checkEq("fill_last_en", 32'(lastEn), 32'd8);
    checkEq("fill_first_we", 32'(firstWe), 32'd5);
    checkEq("fill_i_done", 32'(iDoneCyc), 32'd12);

    // Simultaneous fill requests: D first, I issue starts after the IDLE grant cycle
    clearObs(); iBaseWatch = 16'h1230; cyc = -1;
    raiseI = 1; nIAddr = 16'h1236;
    raiseD = 1; nDWr = 0; nDAddr = 16'h0300; nDWdata = 16'h0;
    repeat (30) step();
    checkEq("tie_d_done", 32'(dDoneCyc), 32'd12);
    checkEq("tie_i_first_en", 32'(iEnCyc), 32'd14);
    checkEq("tie_i_done", 32'(iDoneCyc), 32'd25);

    // Back-to-back ties
    clearObs(); cyc = -1;
    raiseI = 1; nIAddr = 16'h0A00;
    raiseD = 1; nDWr = 1; nDAddr = 16'h0123; nDWdata = 16'h1111; dAgain = 1;
    repeat (40) step();
    checkEq("rr_done_count", 32'(doneLog.size()), 32'd3);
    if (doneLog.size() >= 2) begin
      checkEq("rr_first_grant", 32'(doneLog[0]), 32'd1);
      checkEq("rr_second_grant", 32'(doneLog[1]), RR ? 32'd0 : 32'd1);
    end

    // Single-word write
    clearObs(); cyc = -1;
    raiseD = 1; nDWr = 1; nDAddr = 16'h0040; nDWdata = 16'hBEEF;
    step(); step();
    checkEq("wr_mem_wr", 32'(mem_wr), 32'd1);
    checkEq("wr_mem_addr", 32'(mem_addr), 32'h0040);
    checkEq("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    checkEq("wr_d_done", 32'(d_done), 32'd1);
    repeat (3) step();

    // Reset in the middle of a fill
    clearObs(); cyc = -1;
    raiseI = 1; nIAddr = 16'h2228;
    repeat (7) step();
    nRst = 0; dropAll = 1;
    step();
    nRst = 1; lateFrom = 8;
    step();
    checkEq("midrst_mem_en", 32'(mem_en), 32'd0);
    checkEq("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkEq("midrst_fill_word", 32'(fill_word), 32'd0);
    repeat (8) step();
    checkEq("midrst_late_rvalid", 32'(lateRv), 32'd4);
    checkEq("midrst_late_we", 32'(lateWe), 32'd0);

    // Latency 1, then stray returns while idle
    lat = 1; clearObs(); cyc = -1;
    raiseI = 1; nIAddr = 16'h0F00;
    repeat (12) step();
    checkEq("lat1_i_done", 32'(iDoneCyc), 32'd9);
    checkEq("lat1_first_we", 32'(firstWe), 32'd2);
    strayOn = 1; lateFrom = cyc + 1;
    repeat (12) step();
    checkEq("stray_we", 32'(lateWe), 32'd0);

    // Randomized traffic with random latency and stray returns
    clearObs();
    randMode = 1;
    repeat (3000) step();
    randMode = 0;
    checkEq("rand_progress", 32'(doneLog.size() > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
